// File: rtl/fpm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpm_pkg
// Description : Shared constants and elaboration-time helpers for the
//               multiplier datapath. The helpers size the carry-save
//               reduction tree from the number of partial-product rows.
//                 csa_rows_after(rows, k) : row count after k 3:2 layers
//                 csa_levels(rows)        : layers needed to reach 2 rows
// Revision    : 1.0 - initial release
// ============================================================================
package fpm_pkg;

  localparam int CSA_MIN_ROWS = 3;
  localparam int CSA_MAX_ROWS = 16;

  // Each layer turns every complete triple into two rows; leftovers pass.
  function automatic int csa_rows_after(input int rows, input int k);
    int r;
    r = rows;
    for (int i = 0; i < k; i++) begin
      r = r - (r / 3);
    end
    return r;
  endfunction

  // Bounded loop: row count strictly decreases while above two.
  function automatic int csa_levels(input int rows);
    int r;
    int l;
    r = rows;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (r > 2) begin
        r = r - (r / 3);
        l = l + 1;
      end
    end
    return l;
  endfunction

endpackage : fpm_pkg
`default_nettype wire

// File: rtl/csa32_layer.sv
`default_nettype none
// ============================================================================
// Module      : csa32_layer
// Description : One combinational carry-save layer. Input rows are grouped
//               into triples from row 0 upward; each triple yields a sum row
//               and a carry row (shifted left one, truncated to WIDTH).
//               Output order: all sums, all carries, then pass-through rows.
// Ports       : in_rows  : R_IN rows, row r at [r*WIDTH +: WIDTH]
//               out_rows : csa_rows_after(R_IN,1) rows, same packing
// Revision    : 1.0 - initial release
// ============================================================================
module csa32_layer
  import fpm_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int R_IN  = 3
) (
  input  logic [R_IN*WIDTH-1:0]                       in_rows,
  output logic [csa_rows_after(R_IN, 1)*WIDTH-1:0]    out_rows
);

  localparam int c_TRIPLES = R_IN / 3;
  localparam int c_PASS    = R_IN - (3 * c_TRIPLES);

  for (genvar t = 0; t < c_TRIPLES; t++) begin : g_triple
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-2:0] w_maj;

    assign w_a = in_rows[(3*t)*WIDTH   +: WIDTH];
    assign w_b = in_rows[(3*t+1)*WIDTH +: WIDTH];
    assign w_c = in_rows[(3*t+2)*WIDTH +: WIDTH];

    for (genvar b = 0; b < WIDTH - 1; b++) begin : g_bit
      full u_full (
        .a  (w_a[b]),
        .b  (w_b[b]),
        .ci (w_c[b]),
        .s  (w_s[b]),
        .co (w_maj[b])
      );
    end

    // The carry out of the top bit would shift past WIDTH and is discarded,
    // so the top slice only needs its parity.
    assign w_s[WIDTH-1] = w_a[WIDTH-1] ^ w_b[WIDTH-1] ^ w_c[WIDTH-1];

    assign out_rows[t*WIDTH +: WIDTH]               = w_s;
    assign out_rows[(c_TRIPLES+t)*WIDTH +: WIDTH]   = {w_maj, 1'b0};
  end

  for (genvar p = 0; p < c_PASS; p++) begin : g_pass
    assign out_rows[(2*c_TRIPLES+p)*WIDTH +: WIDTH] =
      in_rows[(3*c_TRIPLES+p)*WIDTH +: WIDTH];
  end

endmodule : csa32_layer
`default_nettype wire

// File: rtl/full.sv
`default_nettype none
// ============================================================================
// Module      : full
// Description : One-bit full adder cell (3:2 compressor bit slice).
// Ports       : a, b, ci : addend bits
//               s        : sum bit (parity)
//               co       : carry bit (majority)
// Revision    : 1.0 - initial release
// ============================================================================
module full (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full
`default_nettype wire

// File: rtl/csa_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csa_reduce_pipe
// Description : Pipelined carry-save reduction tree. Compresses ROWS aligned
//               partial-product rows into one sum row and one carry row via
//               layered 3:2 compressors. A register stage follows every
//               REG_EVERY layers and always follows the last layer; each
//               stage carries a valid bit and uses a collapsing ready chain.
// Ports       : clk, rst_n           : clock, synchronous active-low reset
//               in_valid / in_ready  : operand handshake
//               in_rows              : ROWS rows, row r at [r*WIDTH +: WIDTH]
//               out_valid / out_ready: result handshake
//               out_sum, out_carry   : result rows (carry bit 0 always 0)
// Revision    : 1.0 - initial release
// ============================================================================
module csa_reduce_pipe
  import fpm_pkg::*;
#(
  parameter int WIDTH     = 48,
  parameter int ROWS      = 6,
  parameter int REG_EVERY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] in_rows,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum,
  output logic [WIDTH-1:0]      out_carry
);

  localparam int c_LAYERS = csa_levels(ROWS);

  // Every layer block exposes the valid/ready seen at its boundaries. For an
  // unregistered layer both simply pass through, so a register stage sees the
  // valid of the previous stage and the ready of the next one.
  for (genvar k = 0; k < c_LAYERS; k++) begin : g_layer
    localparam int c_R_IN  = csa_rows_after(ROWS, k);
    localparam int c_R_OUT = csa_rows_after(ROWS, k + 1);
    localparam bit c_REG   = (((k + 1) % REG_EVERY) == 0) || (k == c_LAYERS - 1);

    logic [c_R_IN*WIDTH-1:0]  w_in;
    logic [c_R_OUT*WIDTH-1:0] w_out;
    logic [c_R_OUT*WIDTH-1:0] w_q;
    logic                     w_vin;
    logic                     w_vout;
    logic                     w_rdy_in;
    logic                     w_rdy_out;

    if (k == 0) begin : g_src_port
      assign w_in  = in_rows;
      assign w_vin = in_valid;
    end else begin : g_src_prev
      assign w_in  = g_layer[k-1].w_q;
      assign w_vin = g_layer[k-1].w_vout;
    end

    if (k == c_LAYERS - 1) begin : g_rdy_port
      assign w_rdy_out = out_ready;
    end else begin : g_rdy_next
      assign w_rdy_out = g_layer[k+1].w_rdy_in;
    end

    csa32_layer #(
      .WIDTH (WIDTH),
      .R_IN  (c_R_IN)
    ) u_layer (
      .in_rows  (w_in),
      .out_rows (w_out)
    );

    if (c_REG) begin : g_reg
      logic                     r_valid;
      logic [c_R_OUT*WIDTH-1:0] r_data;

      // An empty stage accepts regardless of downstream stall (bubble collapse).
      assign w_rdy_in = !r_valid || w_rdy_out;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_rdy_in) begin
          r_valid <= w_vin;
          if (w_vin) begin
            r_data <= w_out;
          end
        end
      end

      assign w_vout = r_valid;
      assign w_q    = r_data;
    end else begin : g_comb
      assign w_rdy_in = w_rdy_out;
      assign w_vout   = w_vin;
      assign w_q      = w_out;
    end
  end

  assign in_ready  = g_layer[0].w_rdy_in;
  assign out_valid = g_layer[c_LAYERS-1].w_vout;

  // The last layer always reduces three rows to exactly one sum and one carry.
  assign out_sum   = g_layer[c_LAYERS-1].w_q[WIDTH-1:0];
  assign out_carry = g_layer[c_LAYERS-1].w_q[2*WIDTH-1:WIDTH];

endmodule : csa_reduce_pipe
`default_nettype wire

// File: tb/tb_csa_reduce_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_csa_reduce_pipe
// Description : Scoreboard bench for csa_reduce_pipe in three configurations:
//               A = defaults (48b, 6 rows, REG_EVERY 1)
//               B = 8b, 3 rows, REG_EVERY 1
//               C = 48b, 9 rows, REG_EVERY 2
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_reduce_pipe;

  localparam int AW = 48;
  localparam int AR = 6;
  localparam int BW = 8;
  localparam int BR = 3;
  localparam int CW = 48;
  localparam int CR = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [AR*AW-1:0]  a_in_rows;
  logic [AW-1:0]     a_out_sum, a_out_carry, a_exp_cur;
  logic [AW-1:0]     a_q[$];

  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [BR*BW-1:0]  b_in_rows;
  logic [BW-1:0]     b_out_sum, b_out_carry;
  logic [2*BW-1:0]   b_exp_cur;
  logic [2*BW-1:0]   b_q[$];

  logic              c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [CR*CW-1:0]  c_in_rows;
  logic [CW-1:0]     c_out_sum, c_out_carry, c_exp_cur;
  logic [CW-1:0]     c_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int a_out_seen = 0;

  csa_reduce_pipe #(.WIDTH(AW), .ROWS(AR), .REG_EVERY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_rows(a_in_rows),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_carry(a_out_carry)
  );

  csa_reduce_pipe #(.WIDTH(BW), .ROWS(BR), .REG_EVERY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_rows(b_in_rows),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_carry(b_out_carry)
  );

  csa_reduce_pipe #(.WIDTH(CW), .ROWS(CR), .REG_EVERY(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_rows(c_in_rows),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_carry(c_out_carry)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [AW-1:0] sum_a(input logic [AR*AW-1:0] rows);
    logic [AW-1:0] acc;
    acc = '0;
    for (int r = 0; r < AR; r++) acc = acc + rows[r*AW +: AW];
    return acc;
  endfunction

  function automatic logic [AR*AW-1:0] rand_a();
    logic [AR*AW-1:0] v;
    for (int i = 0; i < AR*AW; i += 32) v[i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [AR*AW-1:0] ramp_a(input int v);
    logic [AR*AW-1:0] rows;
    for (int r = 0; r < AR; r++) rows[r*AW +: AW] = AW'(v * (r + 1));
    return rows;
  endfunction

  // ---------------- scoreboard: push on accepted input ----------------
  always @(negedge clk) if (rst_n && a_in_valid && a_in_ready) a_q.push_back(a_exp_cur);
  always @(negedge clk) if (rst_n && b_in_valid && b_in_ready) b_q.push_back(b_exp_cur);
  always @(negedge clk) if (rst_n && c_in_valid && c_in_ready) c_q.push_back(c_exp_cur);

  // ---------------- monitors: pop on delivered output ----------------
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      a_out_seen++;
      chk("a_carry_lsb", 64'(a_out_carry[0]), 64'd0);
      if (a_q.size() == 0) fail("a_unexpected_output");
      else chk("a_sum_plus_carry", 64'(AW'(a_out_sum + a_out_carry)), 64'(a_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (b_q.size() == 0) fail("b_unexpected_output");
      else chk("b_sum_carry", 64'({b_out_sum, b_out_carry}), 64'(b_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_out_valid && c_out_ready) begin
      chk("c_carry_lsb", 64'(c_out_carry[0]), 64'd0);
      if (c_q.size() == 0) fail("c_unexpected_output");
      else chk("c_sum_plus_carry", 64'(CW'(c_out_sum + c_out_carry)), 64'(c_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [AR*AW-1:0] rows, input logic [AW-1:0] exp);
    int t;
    a_in_rows = rows; a_exp_cur = exp; a_in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!a_in_ready && t < 200) begin @(negedge clk); t++; end
    if (!a_in_ready) fail("a_send_timeout");
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [BR*BW-1:0] rows, input logic [2*BW-1:0] exp);
    int t;
    b_in_rows = rows; b_exp_cur = exp; b_in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!b_in_ready && t < 200) begin @(negedge clk); t++; end
    if (!b_in_ready) fail("b_send_timeout");
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [CR*CW-1:0] rows, input logic [CW-1:0] exp);
    int t;
    c_in_rows = rows; c_exp_cur = exp; c_in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!c_in_ready && t < 200) begin @(negedge clk); t++; end
    if (!c_in_ready) fail("c_send_timeout");
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int t;
    t = 0;
    while (a_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
    #1;
    chk("a_drain_empty", 64'(a_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int               acc;
    int               v;
    int               cnt;
    int               cyc;
    logic             took;
    logic [AR*AW-1:0] r;
    logic [CR*CW-1:0] crows;

    a_in_valid = 0; a_out_ready = 0; a_in_rows = '0; a_exp_cur = '0;
    b_in_valid = 0; b_out_ready = 0; b_in_rows = '0; b_exp_cur = '0;
    c_in_valid = 0; c_out_ready = 0; c_in_rows = '0; c_exp_cur = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("reset_a_out_sum",   64'(a_out_sum),   64'd0);
    chk("reset_a_out_carry", 64'(a_out_carry), 64'd0);
    chk("reset_a_in_ready",  64'(a_in_ready),  64'd1);
    chk("reset_c_out_valid", 64'(c_out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // B: exact sum/carry rows, one-cycle latency
    b_out_ready = 1'b1;
    send_b({8'h03, 8'h02, 8'h01}, {8'h00, 8'h06});
    @(negedge clk);
    chk("b_latency_valid", 64'(b_out_valid), 64'd1);
    @(posedge clk); #1;
    send_b({8'hFF, 8'hFF, 8'hFF}, {8'hFF, 8'hFE});
    send_b({8'h0F, 8'hF0, 8'h55}, {8'hAA, 8'hAA});
    repeat (3) @(posedge clk); #1;
    chk("b_drain_empty", 64'(b_q.size()), 64'd0);

    // A: all-ones rows, out_valid after two further edges
    a_out_ready = 1'b1;
    send_a({AR{48'hFFFF_FFFF_FFFF}}, 48'hFFFF_FFFF_FFFA);
    @(negedge clk); chk("a_lat_edge_n",   64'(a_out_valid), 64'd0);
    @(negedge clk); chk("a_lat_edge_n1",  64'(a_out_valid), 64'd0);
    @(negedge clk); chk("a_lat_edge_n2",  64'(a_out_valid), 64'd1);
    @(posedge clk); #1;
    send_a(ramp_a(1), 48'd21);
    drain_a();

    // C: nine rows of one, two-stage latency
    c_out_ready = 1'b1;
    send_c({CR{48'h0000_0000_0001}}, 48'd9);
    @(negedge clk); chk("c_lat_edge_n",  64'(c_out_valid), 64'd0);
    @(negedge clk); chk("c_lat_edge_n1", 64'(c_out_valid), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < CR; i++) crows[i*CW +: CW] = 48'h8000_0000_0000;
    send_c(crows, 48'h8000_0000_0000);
    repeat (4) @(posedge clk); #1;
    chk("c_drain_empty", 64'(c_q.size()), 64'd0);

    // A: fill with out_ready low, then drain with simultaneous push/pop
    a_out_ready = 1'b0;
    v = 1; acc = 0;
    a_in_rows = ramp_a(v); a_exp_cur = sum_a(ramp_a(v)); a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      took = a_in_ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) begin v++; a_in_rows = ramp_a(v); a_exp_cur = sum_a(ramp_a(v)); end
    end
    chk("a_fill_count", 64'(acc), 64'd3);
    @(negedge clk);
    chk("a_full_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("a_nobubble_out_valid", 64'(a_out_valid), 64'd1);
      chk("a_nobubble_in_ready",  64'(a_in_ready),  64'd1);
      @(posedge clk); #1;
      v++; a_in_rows = ramp_a(v); a_exp_cur = sum_a(ramp_a(v));
    end
    a_in_valid = 1'b0;
    drain_a();

    // A: random operands under random in_valid / out_ready
    took = 1'b1; cnt = 0; cyc = 0;
    while (cnt < 500 && cyc < 20000) begin
      if (!a_in_valid || took) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        r = rand_a();
        a_in_rows = r; a_exp_cur = sum_a(r);
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = a_in_valid && a_in_ready;
      if (took) cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    if (cnt < 500) fail("a_random_budget");
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    drain_a();

    // A: reset with operands in flight and a transfer offered in the reset cycle
    a_out_ready = 1'b0;
    send_a(ramp_a(100), sum_a(ramp_a(100)));
    send_a(ramp_a(200), sum_a(ramp_a(200)));
    a_in_rows = ramp_a(300); a_exp_cur = sum_a(ramp_a(300)); a_in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; a_in_valid = 1'b0;
    a_q.delete();
    @(negedge clk);
    chk("rst_flight_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_flight_out_sum",   64'(a_out_sum),   64'd0);
    chk("rst_flight_out_carry", 64'(a_out_carry), 64'd0);
    chk("rst_flight_in_ready",  64'(a_in_ready),  64'd1);
    a_out_seen = 0;
    a_out_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("rst_no_stale_outputs", 64'(a_out_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_csa_reduce_pipe
`default_nettype wire

// File: doc/csa_reduce_pipe.md
# csa_reduce_pipe

Parametrised, pipelined carry-save reduction tree for the multiplier datapath. Takes ROWS aligned partial-product rows of WIDTH bits and compresses them with layered 3:2 compressors into one sum row and one carry row. Optional pipeline registers between layers, plus a valid/ready handshake. Sits between the Booth partial-product generator and the final carry-propagate adder, replacing the fixed hand-wired reduction stages.

## Interface
- `WIDTH`, 48: bit width of every row and of both outputs.
- `ROWS`, 6: number of input rows; legal range 3..16.
- `REG_EVERY`, 1: a register stage is inserted after every REG_EVERY compressor layers; the final layer is always registered.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: `in_rows` holds a valid operand set.
- `in_ready` output 1: block accepts the operand set this cycle.
- `in_rows` input ROWS*WIDTH: row r occupies bits [r*WIDTH +: WIDTH]. Rows are pre-aligned. Sign handling (inverted-sign / constant-one rows) is done upstream.
- `out_valid` output 1: `out_sum`/`out_carry` are valid.
- `out_ready` input 1: downstream accepts the result this cycle.
- `out_sum` output WIDTH: sum row.
- `out_carry` output WIDTH: carry row, already shifted left by one; bit 0 is always 0.

## Operation
- Layer rule: with r rows entering a layer, the rows are grouped in triples from row 0 upward.
  - Each triple becomes one sum row (XOR) and one carry row (majority << 1, truncated to WIDTH).
  - The remaining r mod 3 rows pass through unchanged.
  - Rows out of the layer = r − floor(r/3).
  - Output order is all sums, then all carries, then the pass-through rows.
- Layers repeat until 2 rows remain. Layer count L(ROWS): 3→1, 4→2, 5→3, 6→3, 7→4, 8→4, 9→4, 10..13→5, 14..16→6.
- Register stage count S = ceil(L / REG_EVERY).
- Arithmetic invariant: (out_sum + out_carry) mod 2^WIDTH == (Σ rows) mod 2^WIDTH. Carries out of bit WIDTH−1 are discarded.
- Each register stage holds a valid bit and its data rows. Handshake is per stage:
  - stage_ready[i] = !valid[i] || stage_ready[i+1], with stage_ready[S] = out_ready.
  - in_ready = stage_ready[0].
  - out_valid = valid[S−1].
- Bubbles collapse: an empty stage loads even while a downstream stage is stalled.
- A stage updates its data only when it loads. Held data stays stable while stalled.

## Timing
- Reset (rst_n=0 at an edge):
  - all valid bits → 0, so out_valid=0 and in_ready=1 from the next cycle;
  - all data registers → 0, so out_sum=0 and out_carry=0;
  - in-flight operands are discarded; a transfer presented in the reset cycle is not accepted.
- Latency: an operand accepted at edge n appears with out_valid=1 after edge n+S−1. With defaults (L=3, S=3), a transfer at edge 0 yields out_valid after edge 2 and a result consumable at edge 3.
- Throughput: one operand per cycle when out_ready=1.
- Capacity: S operands. With out_ready held 0, in_ready falls after S accepted transfers.
- Simultaneous pop and push on a full pipeline are accepted in the same cycle, with no bubble.
- No combinational path from in_* to out_*.
- The only combinational path from out_ready is to in_ready, through the ready chain.

## Structure
- Shared package `fpm_pkg`:
  - constant function `csa_levels(rows)` returning L;
  - constant function `csa_rows_after(rows, k)` returning the row count after k layers.
- Sub-module `csa32_layer` with parameters WIDTH and R_IN. It is one combinational 3:2 layer from R_IN rows to csa_rows_after(R_IN,1) rows, built from the existing `full` cell. The top generates L instances with generated register stages between them.

## Test plan
- WIDTH=8, ROWS=3, REG_EVERY=1:
  - rows 0x01, 0x02, 0x03 → out_sum=0x00, out_carry=0x06, one cycle after acceptance;
  - rows 0xFF, 0xFF, 0xFF → sum 0xFF, carry 0xFE.
- Defaults, all six rows 0xFFFF_FFFF_FFFF → (out_sum+out_carry) mod 2^48 = 0xFFFF_FFFF_FFFA. out_valid rises exactly 3 cycles after the transfer; out_carry[0]=0.
- Defaults, out_ready=0, in_valid=1 continuously:
  - exactly 3 transfers are accepted, then in_ready=0;
  - raising out_ready then drains results in order, with one push per pop and no bubbles.
- Defaults, 500 random operand sets under random in_valid/out_ready → every result satisfies the invariant and arrives in order; none are lost or duplicated.
- Reset asserted with 2 operands in flight → next cycle out_valid=0, out_sum=0, in_ready=1; no stale results appear afterwards.
- ROWS=9, REG_EVERY=2:
  - L=4, S=2, latency 2;
  - nine rows of 0x0000_0000_0001 → sum+carry = 9.
